// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // ceil(w * log10(2)); w*log10(2) is never an integer for w >= 1.
  function automatic int unsigned min_digits(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_DIGIT_W'(5)) begin
      dout = din + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter (double dabble, one bit per clock) with
// start/busy/done handshake and overflow flag. Define SIGNED_EN for two's-complement input.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = min_digits(W)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [W-1:0]                  bus_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf,
  output logic                          sign
);

  localparam int unsigned BW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  if (W < 4 || DIGITS < 1) begin : gen_param_check
    $error("bcd_seq_conv: requires W >= 4 and DIGITS >= 1");
  end

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bcd_work_q;
  logic [W-1:0]    bin_work_q;
  logic            ovf_work_q;
  logic            sign_work_q;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   bcd_shift;
  logic [W-1:0]    bin_shift;
  logic            shift_out;
  logic [W-1:0]    load_val;
  logic            load_sign;

  for (genvar i = 0; i < DIGITS; i++) begin : gen_adj
    bcd_digit_adj u_adj (
      .din (bcd_work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit is a lost carry of 10^DIGITS, i.e. overflow.
  assign {shift_out, bcd_shift, bin_shift} = {adj, bin_work_q, 1'b0};

`ifdef SIGNED_EN
  always_comb begin
    load_sign = bus_in[W-1];
    load_val  = load_sign ? (~bus_in + W'(1)) : bus_in;
  end
`else
  always_comb begin
    load_sign = 1'b0;
    load_val  = bus_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bcd_work_q  <= '0;
      bin_work_q  <= '0;
      ovf_work_q  <= 1'b0;
      sign_work_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
      sign        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            bcd_work_q  <= '0;
            bin_work_q  <= load_val;
            ovf_work_q  <= 1'b0;
            sign_work_q <= load_sign;
            cnt_q       <= CW'(W);
            busy        <= 1'b1;
            state_q     <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          bcd_work_q <= bcd_shift;
          bin_work_q <= bin_shift;
          ovf_work_q <= ovf_work_q | shift_out;
          cnt_q      <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd     <= bcd_shift;
            ovf     <= ovf_work_q | shift_out;
            sign    <= sign_work_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
